// File: rtl/reconf_fir_filter.sv
// reconf_fir_filter: 40-tap FIR built from four 10-tap modules with serially loaded coefficient RAMs.
// Build option FIR_OUT_SATURATE_EN: saturate the output to 16 bits instead of wrapping.
module reconf_fir_filter #(
  parameter int NTAP_PER_MOD = 10,
  parameter int NMOD         = 4,
  parameter int ACC_W        = 24,
  parameter int DATA_W       = 3,
  parameter int COEF_W       = 16
) (
  input  logic                     iClk12M,
  input  logic                     iRsn,
  input  logic                     iEnSample600k,
  input  logic                     iCoeffUpdateFlag,
  input  logic                     iMemRdFlag,
  input  logic [1:0]               iModuleSel,
  input  logic signed [COEF_W-1:0] iWtDtRam,
  input  logic signed [DATA_W-1:0] iFirIn,
  output logic signed [15:0]       oFirOut
);

  localparam int NTAP   = NMOD * NTAP_PER_MOD;
  localparam int CNT_W  = $clog2(NTAP_PER_MOD + 2);
  localparam int ADDR_W = $clog2(NTAP_PER_MOD);
  localparam int MOD_W  = $clog2(NMOD);
  localparam int XI_W   = $clog2(NTAP);
  localparam int PROD_W = COEF_W + DATA_W;
  localparam int OUT_W  = 16;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NTAP_PER_MOD);
`ifdef FIR_OUT_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
`endif

  logic signed [COEF_W-1:0] ram_q [NMOD][NTAP_PER_MOD];
  logic signed [DATA_W-1:0] x_q   [NTAP];
  logic signed [ACC_W-1:0]  acc_q [NMOD];
  logic [CNT_W-1:0]         wc_q, wc_d;
  logic [CNT_W-1:0]         rc_q, rc_d;
  logic [MOD_W-1:0]         rd_mod_q;
  logic signed [OUT_W-1:0]  oFirOut_q;

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic                     rd_go, rd_arm, rd_issue;
  logic [ADDR_W-1:0]        rd_addr;

  logic                     vld_p0;
  logic signed [COEF_W-1:0] coef_p0;
  logic [ADDR_W-1:0]        addr_p0;
  logic [MOD_W-1:0]         mod_p0;
  logic [XI_W-1:0]          x_idx_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic                     mac_en;
  logic signed [ACC_W-1:0]  acc_sum;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return ACC_W'(p);
  endfunction

  function automatic logic signed [OUT_W-1:0] combine(input logic signed [ACC_W-1:0] s);
`ifdef FIR_OUT_SATURATE_EN
    if (s > SAT_MAX)      return OUT_W'(SAT_MAX);
    else if (s < SAT_MIN) return OUT_W'(SAT_MIN);
    else                  return OUT_W'(s);
`else
    return OUT_W'(s);
`endif
  endfunction

  // Write session: count 0 is the arming cycle, counts 1..N write addresses 0..N-1, then hold.
  always_comb begin
    wr_en   = iCoeffUpdateFlag && (wc_q != '0) && (wc_q <= LAST);
    wr_addr = ADDR_W'(wc_q - 1'b1);
    if (!iCoeffUpdateFlag)  wc_d = '0;
    else if (wc_q <= LAST)  wc_d = wc_q + 1'b1;
    else                    wc_d = wc_q;
  end

  // Read session is frozen entirely while a coefficient write session is open.
  always_comb begin
    rd_go    = iMemRdFlag && !iCoeffUpdateFlag;
    rd_arm   = rd_go && (rc_q == '0);
    rd_issue = rd_go && (rc_q != '0) && (rc_q <= LAST);
    rd_addr  = ADDR_W'(rc_q - 1'b1);
    if (iCoeffUpdateFlag)   rc_d = rc_q;
    else if (!iMemRdFlag)   rc_d = '0;
    else if (rc_q <= LAST)  rc_d = rc_q + 1'b1;
    else                    rc_d = rc_q;
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      wc_q     <= '0;
      rc_q     <= '0;
      rd_mod_q <= '0;
      vld_p0   <= 1'b0;
    end else begin
      wc_q   <= wc_d;
      rc_q   <= rc_d;
      vld_p0 <= rd_issue;
      if (rd_arm) rd_mod_q <= iModuleSel;
    end
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int m = 0; m < NMOD; m++)
        for (int k = 0; k < NTAP_PER_MOD; k++)
          ram_q[m][k] <= '0;
    end else if (wr_en) begin
      ram_q[iModuleSel][wr_addr] <= iWtDtRam;
    end
  end

  // Stage p0: registered RAM read, tagged with its tap address and module.
  always_ff @(posedge iClk12M) begin
    if (rd_issue) begin
      coef_p0 <= ram_q[rd_mod_q][rd_addr];
      addr_p0 <= rd_addr;
      mod_p0  <= rd_mod_q;
    end
  end

  always_comb begin
    x_idx_p0 = XI_W'(mod_p0) * XI_W'(NTAP_PER_MOD) + XI_W'(addr_p0);
    prod_p0  = PROD_W'(coef_p0) * PROD_W'(x_q[x_idx_p0]);
    mac_en   = vld_p0 && !iCoeffUpdateFlag;
  end

  // Stage p1: accumulate; arming a module clears its accumulator.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int m = 0; m < NMOD; m++) acc_q[m] <= '0;
    end else begin
      if (mac_en) acc_q[mod_p0] <= acc_q[mod_p0] + sext_prod(prod_p0);
      if (rd_arm) acc_q[iModuleSel] <= '0;
    end
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int k = 0; k < NTAP; k++) x_q[k] <= '0;
    end else if (iEnSample600k) begin
      for (int k = NTAP - 1; k > 0; k--) x_q[k] <= x_q[k-1];
      x_q[0] <= iFirIn;
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int m = 0; m < NMOD; m++) acc_sum = acc_sum + acc_q[m];
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn)              oFirOut_q <= '0;
    else if (iEnSample600k) oFirOut_q <= combine(acc_sum);
  end

  assign oFirOut = oFirOut_q;

endmodule

// File: tb/tb_reconf_fir_filter.sv
// Self-checking bench for reconf_fir_filter against an arithmetic FIR model.
module tb_reconf_fir_filter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, cuf = 1'b0, mrf = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] wdata = 16'd0;
  logic [2:0]  firin = 3'd0;
  logic [15:0] fir_out;

  int checks = 0;
  int errors = 0;

  int          m_ram [4][10];
  int          m_x   [40];
  int          m_acc [4];
  logic [15:0] m_out;
  logic [15:0] wbuf  [10];

  reconf_fir_filter dut (
    .iClk12M(clk), .iRsn(rst_n), .iEnSample600k(en), .iCoeffUpdateFlag(cuf),
    .iMemRdFlag(mrf), .iModuleSel(sel), .iWtDtRam(wdata), .iFirIn(firin),
    .oFirOut(fir_out)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] mcombine(input int s);
`ifdef FIR_OUT_SATURATE_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return s[15:0];
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      m_acc[m] = 0;
      for (int k = 0; k < 10; k++) m_ram[m][k] = 0;
    end
    for (int k = 0; k < 40; k++) m_x[k] = 0;
    m_out = 16'h0000;
  endtask

  task automatic apply_reset();
    en = 0; cuf = 0; mrf = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    cyc();
  endtask

  task automatic do_strobe(input int xin);
    int s;
    firin = xin[2:0]; en = 1; cyc(); en = 0;
    firin = 3'($urandom);
    s = m_acc[0] + m_acc[1] + m_acc[2] + m_acc[3];
    m_out = mcombine(s);
    for (int k = 39; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = xin;
  endtask

  task automatic write_mod(input int m);
    sel = 2'(m); cuf = 1; wdata = 16'hDEAD; cyc();
    for (int k = 0; k < 10; k++) begin wdata = wbuf[k]; cyc(); end
    cuf = 0; wdata = 16'($urandom); cyc();
    for (int k = 0; k < 10; k++) m_ram[m][k] = int'($signed(wbuf[k]));
  endtask

  function automatic int model_sum(input int m, input int n);
    int s = 0;
    for (int k = 0; k < n && k < 10; k++) s += m_ram[m][k] * m_x[10*m + k];
    return s;
  endfunction

  task automatic read_mod(input int m, input int n);
    sel = 2'(m); mrf = 1;
    repeat (n) begin cyc(); sel = 2'($urandom); end
    mrf = 0; repeat (3) cyc();
    m_acc[m] = model_sum(m, n - 1);
  endtask

  task automatic test_reset();
    int bad = 0;
    apply_reset();
    checks++;
    if (fir_out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", fir_out); end
    for (int m = 0; m < 4; m++) begin
      if (dut.acc_q[m] !== 24'd0) bad++;
      for (int k = 0; k < 10; k++) if (dut.ram_q[m][k] !== 16'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_state: %0d nonzero words, want 0", bad); end
    read_mod(2, 11);
    do_strobe(0);
    checks++;
    if (fir_out !== 16'h0000) begin errors++; $display("FAIL zero_ram_session: got %h want 0000", fir_out); end
  endtask

  task automatic test_load();
    logic [15:0] exp;
    int bad;
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 10; k++) wbuf[k] = 16'(16'h0A00 + m*16'h0100 + k);
      write_mod(m);
    end
    for (int m = 0; m < 4; m++) begin
      bad = 0;
      for (int k = 0; k < 10; k++) begin
        exp = 16'(16'h0A00 + m*16'h0100 + k);
        if (dut.ram_q[m][k] !== exp) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL load_mod%0d: %0d wrong words, want 0", m, bad); end
    end
    sel = 2'd3; cuf = 1; wdata = 16'hDEAD; cyc(); cuf = 0; cyc();
    bad = 0;
    for (int k = 0; k < 10; k++) if (dut.ram_q[3][k] !== 16'(m_ram[3][k])) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL arm_only_write: %0d words changed, want 0", bad); end
  endtask

  task automatic test_impulse();
    do_strobe(-1);
    read_mod(0, 11);
    do_strobe(0);
    checks++;
    if (fir_out !== 16'hF600 || m_out !== 16'hF600) begin
      errors++; $display("FAIL impulse_tap0: got %h model %h want F600", fir_out, m_out);
    end
    read_mod(0, 11);
    do_strobe(0);
    checks++;
    if (fir_out !== 16'hF5FF || m_out !== 16'hF5FF) begin
      errors++; $display("FAIL impulse_tap1: got %h model %h want F5FF", fir_out, m_out);
    end
  endtask

  task automatic test_tap15();
    repeat (13) do_strobe(0);
    read_mod(1, 11);
    read_mod(0, 11);
    do_strobe(0);
    checks++;
    if (fir_out !== 16'hF4FB || m_out !== 16'hF4FB) begin
      errors++; $display("FAIL impulse_tap15: got %h model %h want F4FB", fir_out, m_out);
    end
  endtask

  task automatic test_max();
    logic [15:0] want;
`ifdef FIR_OUT_SATURATE_EN
    want = 16'h7FFF;
`else
    want = 16'hFFE2;
`endif
    apply_reset();
    for (int k = 0; k < 10; k++) wbuf[k] = 16'h7FFF;
    write_mod(0);
    repeat (10) do_strobe(3);
    read_mod(0, 11);
    do_strobe(0);
    checks++;
    if (fir_out !== want || m_out !== want) begin
      errors++; $display("FAIL max_input: got %h model %h want %h", fir_out, m_out, want);
    end
  endtask

  task automatic test_priority();
    int bad = 0;
    sel = 2'd2; cuf = 1; mrf = 1; wdata = 16'h1234;
    repeat (11) cyc();
    cuf = 0; mrf = 0; repeat (3) cyc();
    for (int k = 0; k < 10; k++) m_ram[2][k] = 32'h1234;
    for (int k = 0; k < 10; k++) if (dut.ram_q[2][k] !== 16'h1234) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL priority_write: %0d wrong words, want 0", bad); end
    checks++;
    if (dut.acc_q[2] !== 24'(m_acc[2])) begin
      errors++; $display("FAIL priority_acc: got %h want %h", dut.acc_q[2], 24'(m_acc[2]));
    end
    do_strobe(0);
    checks++;
    if (fir_out !== m_out) begin errors++; $display("FAIL priority_out: got %h want %h", fir_out, m_out); end
  endtask

  task automatic test_reset_mid_write();
    int bad_ram = 0, bad_acc = 0, bad_x = 0;
    sel = 2'd1; cuf = 1; wdata = 16'($urandom);
    repeat (5) cyc();
    #2 rst_n = 0;
    #1;
    for (int m = 0; m < 4; m++) begin
      if (dut.acc_q[m] !== 24'd0) bad_acc++;
      for (int k = 0; k < 10; k++) if (dut.ram_q[m][k] !== 16'd0) bad_ram++;
    end
    for (int k = 0; k < 40; k++) if (dut.x_q[k] !== 3'd0) bad_x++;
    checks++;
    if (bad_ram != 0) begin errors++; $display("FAIL midreset_ram: %0d nonzero, want 0", bad_ram); end
    checks++;
    if (bad_acc != 0) begin errors++; $display("FAIL midreset_acc: %0d nonzero, want 0", bad_acc); end
    checks++;
    if (bad_x != 0) begin errors++; $display("FAIL midreset_delay: %0d nonzero, want 0", bad_x); end
    checks++;
    if (fir_out !== 16'h0000) begin errors++; $display("FAIL midreset_out: got %h want 0000", fir_out); end
    cuf = 0;
    @(posedge clk); #1 rst_n = 1;
    model_reset();
    cyc();
  endtask

  task automatic test_back_to_back();
    int a, b;
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 10; k++) wbuf[k] = 16'($urandom);
      write_mod(m);
    end
    for (int i = 0; i < 40; i++) do_strobe(int'($urandom_range(0, 7)) - 4);
    a = int'($urandom_range(0, 3));
    b = (a + 1 + int'($urandom_range(0, 2))) % 4;
    sel = 2'(a); mrf = 1;
    repeat (11) begin cyc(); sel = 2'($urandom); end
    mrf = 0; cyc();
    sel = 2'(b); mrf = 1;
    repeat (11) begin cyc(); sel = 2'($urandom); end
    mrf = 0; repeat (3) cyc();
    m_acc[a] = model_sum(a, 10);
    m_acc[b] = model_sum(b, 10);
    do_strobe(0);
    checks++;
    if (fir_out !== m_out) begin
      errors++; $display("FAIL back_to_back m%0d/m%0d: got %h want %h", a, b, fir_out, m_out);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 4; it++) begin
      for (int m = 0; m < 4; m++) begin
        for (int k = 0; k < 10; k++) wbuf[k] = 16'($urandom);
        write_mod(m);
      end
      for (int i = 0; i < 20; i++) begin
        do_strobe(int'($urandom_range(0, 7)) - 4);
        checks++;
        if (fir_out !== m_out) begin
          errors++; $display("FAIL random_hold it%0d s%0d: got %h want %h", it, i, fir_out, m_out);
        end
      end
      for (int m = 0; m < 4; m++) begin
        n = (it == 0) ? 11 : int'($urandom_range(1, 13));
        read_mod(m, n);
      end
      do_strobe(int'($urandom_range(0, 7)) - 4);
      checks++;
      if (fir_out !== m_out) begin
        errors++; $display("FAIL random_sessions it%0d: got %h want %h", it, fir_out, m_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_impulse();
    test_tap15();
    test_max();
    test_priority();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
